// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte requesters.
// Optional burst lock is enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     ack,
  output logic [ID_WIDTH-1:0]    grant_id,
  output logic                   arb_busy,
  output logic                   uart_en,
  output logic                   uart_we,
  output logic [7:0]             uart_data,
  input  logic                   uart_tx_busy,
  input  logic                   uart_tx_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, DRAIN} state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] ptr;
  logic [NUM_REQ-1:0]  eligible;
  logic                pick_valid;
  logic [ID_WIDTH-1:0] pick_id;
  logic [7:0]          pick_data;
  logic [NUM_REQ-1:0]  pick_onehot;
  int                  best_dist;
  int                  dist_i;

`ifdef UART_ARB_LOCK_EN
  logic                lock;
  logic [ID_WIDTH-1:0] lock_id;
  logic                pick_last;

  // While a burst is locked only its owner may win, even if it drops req.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
      assign eligible[gi] = req[gi] & (~lock | (lock_id == ID_WIDTH'(gi)));
    end
  endgenerate
`else
  logic unused_req_last;
  assign unused_req_last = ^req_last;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
      assign eligible[gi] = req[gi];
    end
  endgenerate
`endif

  // Winner is the eligible requester closest above ptr, wrapping around.
  always_comb begin
    pick_valid  = |eligible;
    pick_id     = '0;
    pick_data   = '0;
    pick_onehot = '0;
    best_dist   = NUM_REQ;
    dist_i      = 0;
`ifdef UART_ARB_LOCK_EN
    pick_last   = 1'b0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      dist_i = (i + 2 * NUM_REQ - 1 - int'(ptr)) % NUM_REQ;
      if (eligible[i] && (dist_i < best_dist)) begin
        best_dist      = dist_i;
        pick_id        = ID_WIDTH'(i);
        pick_data      = req_data[8*i +: 8];
        pick_onehot    = '0;
        pick_onehot[i] = 1'b1;
`ifdef UART_ARB_LOCK_EN
        pick_last      = req_last[i];
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ack       <= '0;
      grant_id  <= '0;
      arb_busy  <= 1'b0;
      uart_en   <= 1'b0;
      uart_we   <= 1'b0;
      uart_data <= '0;
      ptr       <= ID_WIDTH'(NUM_REQ - 1);
`ifdef UART_ARB_LOCK_EN
      lock      <= 1'b0;
      lock_id   <= '0;
`endif
    end else begin
      uart_en <= 1'b1;
      ack     <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            ack       <= pick_onehot;
            uart_data <= pick_data;
            grant_id  <= pick_id;
            ptr       <= pick_id;
            uart_we   <= 1'b1;
            arb_busy  <= 1'b1;
            state     <= ISSUE;
`ifdef UART_ARB_LOCK_EN
            lock      <= ~pick_last;
            lock_id   <= pick_id;
`endif
          end
        end
        ISSUE: begin
          if (uart_tx_busy) begin
            uart_we <= 1'b0;
            state   <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (uart_tx_done) begin
            if (!uart_tx_busy) begin
              state    <= IDLE;
              arb_busy <= 1'b0;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!uart_tx_busy) begin
            state    <= IDLE;
            arb_busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          arb_busy <= 1'b0;
          uart_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule
